// File: rtl/zap_wb_pkg.sv
// Shared Wishbone definitions for the ZAP bus slaves: cycle-type codes,
// slave FSM states and the wait-counter width.
package zap_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int WB_WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } wb_slv_state_t;

endpackage

// File: rtl/zap_wb_sram_array.sv
// Single-port word array with per-byte write enables and a registered,
// write-first read port.
module zap_wb_sram_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_be,
  input  logic [31:0]   i_wdat,
  output logic [31:0]   o_rdat
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: no reset here -- a memory array cannot be cleared in one cycle, and
  // the read register is only observed after the FSM has presented an address.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_be[b]) begin
        mem[i_addr][8*b +: 8] <= i_wdat[8*b +: 8];
        o_rdat[8*b +: 8]      <= i_wdat[8*b +: 8];
      end else begin
        o_rdat[8*b +: 8]      <= mem[i_addr][8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/zap_wb_sram_slave.sv
// Wishbone B3 registered-feedback slave in front of an on-chip SRAM; serves
// classic and incrementing-burst cycles with programmable wait states.
module zap_wb_sram_slave
  import zap_wb_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 32'd1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned FIRST_WAIT  = 32'd1,
  parameter int unsigned BURST_WAIT  = 32'd0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_wen,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [2:0]  i_wb_cti,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_wb_err
);

  localparam int unsigned          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0]          WIN_BYTES = 32'(DEPTH_WORDS) << 2;
  localparam logic [WB_WAIT_W-1:0] FIRST_W   = WB_WAIT_W'(FIRST_WAIT);
  localparam logic [WB_WAIT_W-1:0] BURST_W   = WB_WAIT_W'(BURST_WAIT);

  wb_slv_state_t        state;
  logic                 ack_ff;
  logic [WB_WAIT_W-1:0] wcnt;
  logic [29:0]          beat_addr;
  logic [29:0]          beat_addr_nxt;
  logic [31:0]          beat_byte;
  logic                 in_range;
  logic                 ack_gated;
  logic                 burst_next;
  logic                 wr_en;
  logic [AW-1:0]        mem_addr;
  logic [3:0]           mem_be;
  logic [31:0]          mem_rdat;
  logic                 unused_adr_lsb;

  assign unused_adr_lsb = ^i_wb_adr[1:0];

  // Unsigned wrap makes addresses below BASE_ADDR fall out of range as well.
  assign beat_byte  = {beat_addr, 2'b00};
  assign in_range   = (beat_byte - BASE_ADDR) < WIN_BYTES;
  assign ack_gated  = ack_ff & i_wb_cyc & i_wb_stb;
  assign burst_next = ack_gated & (i_wb_cti == CTI_INCR);
  assign wr_en      = ack_gated & i_wb_wen & in_range & ~i_reset;

  assign o_wb_ack = ack_gated;
  assign o_wb_err = ack_gated & ~in_range;
  assign o_wb_dat = (ack_ff && in_range) ? mem_rdat : 32'h0;

  // NOTE: every path assigns beat_addr_nxt, starting from a default, so this
  // block stays purely combinational and infers no latch.
  always_comb begin
    beat_addr_nxt = beat_addr;
    if (state == IDLE && i_wb_cyc && i_wb_stb) begin
      beat_addr_nxt = i_wb_adr[31:2];
    end else if (state == ACK && burst_next) begin
      beat_addr_nxt = beat_addr + 30'd1;
    end
  end

  // The port reads one cycle ahead so data is registered on entry to ACK;
  // during a write it points at the beat being written instead.
  assign mem_addr = wr_en ? beat_addr[AW-1:0] : beat_addr_nxt[AW-1:0];
  assign mem_be   = wr_en ? i_wb_sel : 4'b0000;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here samples values from before this edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      ack_ff    <= 1'b0;
      wcnt      <= '0;
      beat_addr <= '0;
    end else begin
      beat_addr <= beat_addr_nxt;
      ack_ff    <= 1'b0;
      case (state)
        IDLE: begin
          if (i_wb_cyc && i_wb_stb) begin
            wcnt <= FIRST_W;
            if (FIRST_W != '0) begin
              state <= WAIT;
            end else begin
              state  <= ACK;
              ack_ff <= 1'b1;
            end
          end
        end
        WAIT: begin
          wcnt <= wcnt - 1'b1;
          if (!i_wb_cyc) begin
            state <= IDLE;
          end else if (wcnt <= 1) begin
            state  <= ACK;
            ack_ff <= 1'b1;
          end
        end
        ACK: begin
          if (burst_next) begin
            wcnt <= BURST_W;
            if (BURST_W != '0) begin
              state <= WAIT;
            end else begin
              state  <= ACK;
              ack_ff <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  zap_wb_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .i_clk  (i_clk),
    .i_addr (mem_addr),
    .i_be   (mem_be),
    .i_wdat (i_wb_dat),
    .o_rdat (mem_rdat)
  );

endmodule

// File: tb/tb_zap_wb_sram_slave.sv
// Directed bench for zap_wb_sram_slave: instance A (FIRST_WAIT=2, BURST_WAIT=0)
// and instance B (FIRST_WAIT=0, BURST_WAIT=2) share one bus, each with its own cyc.
module tb_zap_wb_sram_slave;
  import zap_wb_pkg::*;

  localparam int FW_A = 2;
  localparam int BW_A = 0;
  localparam int FW_B = 0;
  localparam int BW_B = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc_a, cyc_b, stb, wen;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic [2:0]  cti;
  logic [31:0] dat_a, dat_b;
  logic        ack_a, err_a, ack_b, err_b;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] wq [8];
  logic [31:0] rq [8];
  logic        aq [8];
  logic        eq [8];
  int          bcyc [8];
  int          first_lat;

  always #5 clk = ~clk;

  zap_wb_sram_slave #(
    .DEPTH_WORDS (1024), .BASE_ADDR (32'h0), .FIRST_WAIT (FW_A), .BURST_WAIT (BW_A)
  ) dut_a (
    .i_clk (clk), .i_reset (rst), .i_wb_cyc (cyc_a), .i_wb_stb (stb), .i_wb_wen (wen),
    .i_wb_sel (sel), .i_wb_adr (adr), .i_wb_dat (wdat), .i_wb_cti (cti),
    .o_wb_dat (dat_a), .o_wb_ack (ack_a), .o_wb_err (err_a)
  );

  zap_wb_sram_slave #(
    .DEPTH_WORDS (1024), .BASE_ADDR (32'h0), .FIRST_WAIT (FW_B), .BURST_WAIT (BW_B)
  ) dut_b (
    .i_clk (clk), .i_reset (rst), .i_wb_cyc (cyc_b), .i_wb_stb (stb), .i_wb_wen (wen),
    .i_wb_sel (sel), .i_wb_adr (adr), .i_wb_dat (wdat), .i_wb_cti (cti),
    .o_wb_dat (dat_b), .o_wb_ack (ack_b), .o_wb_err (err_b)
  );

  task automatic bus_idle();
    cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0; wen = 1'b0;
    sel = 4'h0; adr = 32'h0; wdat = 32'h0; cti = CTI_CLASSIC;
  endtask

  // Drives an A transaction of n beats but only the first n_drive of them;
  // records per-beat ack/err/data and the first-ACK latency in cycles.
  task automatic run_a(input logic [31:0] a, input logic w, input logic [3:0] s,
                       input int n, input int n_drive);
    for (int i = 0; i < 8; i++) begin
      aq[i] = 1'b0; eq[i] = 1'b0; rq[i] = 32'h0;
    end
    cyc_a = 1'b1; stb = 1'b1; adr = a; wen = w; sel = s; wdat = wq[0];
    cti = (n == 1) ? CTI_CLASSIC : CTI_INCR;
    first_lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ack_a) begin
        first_lat = c;
        break;
      end
    end
    aq[0] = ack_a; eq[0] = err_a; rq[0] = dat_a;
    for (int i = 1; i < n_drive; i++) begin
      @(posedge clk); #1;
      wdat = wq[i];
      cti  = (i == n - 1) ? CTI_EOB : CTI_INCR;
      @(negedge clk);
      aq[i] = ack_a; eq[i] = err_a; rq[i] = dat_a;
    end
    @(posedge clk); #1;
    bus_idle();
    @(posedge clk); #1;
  endtask

  // Drives a full-select B transaction; the ACK cycle of each beat goes to
  // bcyc. With reset_beat >= 0, reset is pulsed in the wait before that beat.
  task automatic run_b(input logic [31:0] a, input logic w, input int n, input int reset_beat);
    int c;
    c = 0;
    for (int i = 0; i < 8; i++) bcyc[i] = -1;
    cyc_b = 1'b1; stb = 1'b1; adr = a; wen = w; sel = 4'hF; wdat = wq[0];
    cti = (n == 1) ? CTI_CLASSIC : CTI_INCR;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        c++;
        wdat = wq[i];
        cti  = (i == n - 1) ? CTI_EOB : CTI_INCR;
      end
      if (i == reset_beat) begin
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ack_b !== 1'b0 || err_b !== 1'b0)
          $display("FAIL reset_mid_burst: ack=%b err=%b, want 0 0", ack_b, err_b);
        else n_pass++;
        break;
      end
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (ack_b) begin
          bcyc[i] = c; rq[i] = dat_b; eq[i] = err_b;
          break;
        end
        c++;
      end
    end
    @(posedge clk); #1;
    bus_idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ack_a !== 1'b0) $display("FAIL reset_ack: got %b want 0", ack_a); else n_pass++;
    n_checks++; if (err_a !== 1'b0) $display("FAIL reset_err: got %b want 0", err_a); else n_pass++;
    n_checks++; if (dat_a !== 32'h0) $display("FAIL reset_dat: got %h want 0", dat_a); else n_pass++;
    n_checks++; if (ack_b !== 1'b0) $display("FAIL reset_ack_b: got %b want 0", ack_b); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_classic_read();
    int lat;
    wq[0] = 32'hDEADBEEF;
    run_a(32'h40, 1'b1, 4'hF, 1, 1);
    n_checks++; if (first_lat != FW_A + 1) $display("FAIL classic_wr_lat: got %0d want %0d", first_lat, FW_A + 1); else n_pass++;
    n_checks++; if (eq[0] !== 1'b0) $display("FAIL classic_wr_err: got %b want 0", eq[0]); else n_pass++;
    // Hold cyc/stb one cycle past the ACK: it must not be repeated.
    cyc_a = 1'b1; stb = 1'b1; adr = 32'h40; wen = 1'b0; sel = 4'hF; cti = CTI_CLASSIC;
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ack_a) begin
        lat = c;
        break;
      end
    end
    n_checks++; if (lat != FW_A + 1) $display("FAIL classic_rd_lat: got %0d want %0d", lat, FW_A + 1); else n_pass++;
    n_checks++; if (dat_a !== 32'hDEADBEEF) $display("FAIL classic_rd_dat: got %h want deadbeef", dat_a); else n_pass++;
    n_checks++; if (err_a !== 1'b0) $display("FAIL classic_rd_err: got %b want 0", err_a); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (ack_a !== 1'b0) $display("FAIL classic_single_ack: got %b want 0", ack_a); else n_pass++;
    @(posedge clk); #1;
    bus_idle();
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int n_ok;
    for (int i = 0; i < 8; i++) wq[i] = 32'(i);
    run_a(32'h100, 1'b1, 4'hF, 8, 8);
    n_checks++; if (first_lat != FW_A + 1) $display("FAIL burst_wr_lat: got %0d want %0d", first_lat, FW_A + 1); else n_pass++;
    n_ok = 0;
    for (int i = 0; i < 8; i++) if (aq[i] === 1'b1 && eq[i] === 1'b0) n_ok++;
    n_checks++; if (n_ok != 8) $display("FAIL burst_wr_acks: got %0d want 8", n_ok); else n_pass++;
    run_a(32'h100, 1'b0, 4'hF, 8, 8);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({aq[i], eq[i], rq[i]} !== {1'b1, 1'b0, 32'(i)})
        $display("FAIL burst_rd_beat%0d: ack=%b err=%b dat=%h want 1 0 %h", i, aq[i], eq[i], rq[i], 32'(i));
      else n_pass++;
    end
    run_a(32'h11C, 1'b0, 4'hF, 1, 1);
    n_checks++; if (rq[0] !== 32'h7) $display("FAIL burst_readback_0x47: got %h want 7", rq[0]); else n_pass++;
  endtask

  task automatic test_byte_lanes();
    wq[0] = 32'h11223344;
    run_a(32'h200, 1'b1, 4'hF, 1, 1);
    wq[0] = 32'hAABBCCDD;
    run_a(32'h200, 1'b1, 4'b0101, 1, 1);
    run_a(32'h200, 1'b0, 4'hF, 1, 1);
    n_checks++; if (rq[0] !== 32'h11BB33DD) $display("FAIL lanes_0101: got %h want 11bb33dd", rq[0]); else n_pass++;
    wq[0] = 32'hFFFFFFFF;
    run_a(32'h200, 1'b1, 4'b0000, 1, 1);
    n_checks++; if (aq[0] !== 1'b1 || eq[0] !== 1'b0) $display("FAIL lanes_sel0_ack: ack=%b err=%b want 1 0", aq[0], eq[0]); else n_pass++;
    run_a(32'h200, 1'b0, 4'hF, 1, 1);
    n_checks++; if (rq[0] !== 32'h11BB33DD) $display("FAIL lanes_sel0_keep: got %h want 11bb33dd", rq[0]); else n_pass++;
  endtask

  task automatic test_out_of_range();
    logic [31:0] exp_rd [4];
    logic [31:0] rd_adr [4];
    wq[0] = 32'hA5A50000; run_a(32'h0, 1'b1, 4'hF, 1, 1);
    wq[0] = 32'hA5A50001; run_a(32'h4, 1'b1, 4'hF, 1, 1);
    run_a(32'h1000, 1'b0, 4'hF, 1, 1);
    n_checks++; if (aq[0] !== 1'b1) $display("FAIL oor_ack: got %b want 1", aq[0]); else n_pass++;
    n_checks++; if (eq[0] !== 1'b1) $display("FAIL oor_err: got %b want 1", eq[0]); else n_pass++;
    n_checks++; if (rq[0] !== 32'h0) $display("FAIL oor_dat: got %h want 0", rq[0]); else n_pass++;
    for (int i = 0; i < 4; i++) wq[i] = 32'hB0 + 32'(i);
    run_a(32'hFF8, 1'b1, 4'hF, 4, 4);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({aq[i], eq[i]} !== {1'b1, (i >= 2) ? 1'b1 : 1'b0})
        $display("FAIL oor_burst_beat%0d: ack=%b err=%b want 1 %0d", i, aq[i], eq[i], (i >= 2) ? 1 : 0);
      else n_pass++;
    end
    rd_adr[0] = 32'hFF8; exp_rd[0] = 32'hB0;
    rd_adr[1] = 32'hFFC; exp_rd[1] = 32'hB1;
    rd_adr[2] = 32'h0;   exp_rd[2] = 32'hA5A50000;
    rd_adr[3] = 32'h4;   exp_rd[3] = 32'hA5A50001;
    for (int i = 0; i < 4; i++) begin
      run_a(rd_adr[i], 1'b0, 4'hF, 1, 1);
      n_checks++;
      if (rq[0] !== exp_rd[i]) $display("FAIL oor_readback_%h: got %h want %h", rd_adr[i], rq[0], exp_rd[i]);
      else n_pass++;
    end
  endtask

  task automatic test_cyc_drop();
    run_a(32'h100, 1'b0, 4'hF, 8, 3);
    n_checks++;
    if ({aq[0], aq[1], aq[2], rq[0], rq[1], rq[2]} !== {3'b111, 32'h0, 32'h1, 32'h2})
      $display("FAIL drop_first_beats: acks=%b%b%b dat=%h %h %h want 111 0 1 2",
               aq[0], aq[1], aq[2], rq[0], rq[1], rq[2]);
    else n_pass++;
    run_a(32'h104, 1'b0, 4'hF, 1, 1);
    n_checks++; if (first_lat != FW_A + 1) $display("FAIL drop_next_lat: got %0d want %0d", first_lat, FW_A + 1); else n_pass++;
    n_checks++; if (rq[0] !== 32'h1) $display("FAIL drop_next_dat: got %h want 1", rq[0]); else n_pass++;
  endtask

  task automatic test_burst_wait_reset();
    for (int i = 0; i < 4; i++) wq[i] = 32'h70 + 32'(i);
    run_b(32'h80, 1'b1, 4, -1);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bcyc[i] != FW_B + 1 + i * (BW_B + 1))
        $display("FAIL bwait_ack_cycle%0d: got %0d want %0d", i, bcyc[i], FW_B + 1 + i * (BW_B + 1));
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) wq[i] = 32'h90 + 32'(i);
    run_b(32'h80, 1'b1, 4, 2);
    run_b(32'h80, 1'b0, 4, -1);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({eq[i], rq[i]} !== {1'b0, (i < 2) ? 32'h90 + 32'(i) : 32'h70 + 32'(i)})
        $display("FAIL reset_readback%0d: err=%b dat=%h want 0 %h", i, eq[i], rq[i],
                 (i < 2) ? 32'h90 + 32'(i) : 32'h70 + 32'(i));
      else n_pass++;
    end
    n_checks++; if (bcyc[3] != FW_B + 1 + 3 * (BW_B + 1)) $display("FAIL reset_fresh_timing: got %0d want %0d", bcyc[3], FW_B + 1 + 3 * (BW_B + 1)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_classic_read();
    test_back_to_back();
    test_byte_lanes();
    test_out_of_range();
    test_cyc_drop();
    test_burst_wait_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
